matrix_row_streamer: RTL

Parametrised successor to the fixed 16x256 matrix row splitter. Captures a flat ROWS*ROW_W matrix word with a valid/ready handshake. Delivers the matrix in one of two modes: serially, one row per handshake, to a single PE row; or in parallel, as the whole matrix held stable until acknowledged. Sits between the matrix buffer / DMA side and the PE array input; signals completion with a one-cycle done pulse.

---
 rtl/matrix_row_streamer.sv | 116 +++++++++++
 1 files changed

// File: rtl/matrix_row_streamer.sv
// Captures a flat ROWS x ROW_W matrix and delivers it either one row per
// handshake (serial) or as the whole held matrix (parallel), then pulses done.
module matrix_row_streamer #(
  parameter  int ROW_W = 256,
  parameter  int ROWS  = 16,
  localparam int IDX_W = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*ROW_W-1:0] in_matrix,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROW_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  par_valid,
  output logic [ROWS*ROW_W-1:0] par_matrix,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_PAR    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_t                r_state;
  logic [ROWS*ROW_W-1:0] r_buf;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_mode;
  logic                  r_out_valid;
  logic                  r_par_valid;
  logic                  r_done;

  logic [ROW_W-1:0]      w_rows [ROWS];
  logic                  w_stream;
  logic                  w_par;

  // Row 0 sits in the most significant slice of the flat word.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_rows
    assign w_rows[gr] = r_buf[(ROWS-gr)*ROW_W-1 -: ROW_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_idx       <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_par_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_buf  <= in_matrix;
            r_mode <= mode;
            r_idx  <= '0;
            if (mode) begin
              r_state     <= S_PAR;
              r_par_valid <= 1'b1;
            end else begin
              r_state     <= S_STREAM;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= S_IDLE;
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_par_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_par_valid <= 1'b0;
        end
      endcase
    end
  end

  // The captured mode qualifies the valids so a stale state can never expose the wrong view.
  assign w_stream   = r_out_valid && !r_mode;
  assign w_par      = r_par_valid && r_mode;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = w_stream;
  assign out_row    = w_stream ? w_rows[r_idx] : '0;
  assign out_idx    = r_idx;
  assign out_last   = w_stream && (r_idx == LAST_IDX);
  assign par_valid  = w_par;
  assign par_matrix = w_par ? r_buf : '0;
  assign done       = r_done;

endmodule
